// File: rtl/trap_pkg.sv
// trap_pkg: shared definitions for the machine-mode trap controller.
//   - FSM state encoding
//   - exception cause codes (illegal instruction, breakpoint, environment calls)
//   - mstatus field positions (MIE, MPIE, MPP)
//   - privilege level encodings
//   - small helpers for word alignment and ecall cause selection
package trap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEnter,
        StExit,
        StRedirect
    } trap_state_e;

    localparam logic [3:0] CauseIllegalInstr = 4'd2;
    localparam logic [3:0] CauseBreakpoint   = 4'd3;
    localparam logic [3:0] CauseEcallU       = 4'd8;
    localparam logic [3:0] CauseEcallS       = 4'd9;
    localparam logic [3:0] CauseEcallM       = 4'd11;

    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;
    localparam int unsigned MstatusMppHi = 12;

    localparam logic [1:0] PrivU = 2'd0;
    localparam logic [1:0] PrivS = 2'd1;
    localparam logic [1:0] PrivM = 2'd3;

    // Clear the two low bits of an address (mepc / mtvec base / trap PC).
    function automatic logic [63:0] align4(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

    // Environment-call cause depends on the privilege the ecall came from.
    function automatic logic [3:0] ecall_cause(input logic [1:0] priv);
        logic [3:0] code;
        unique case (priv)
            PrivU:   code = CauseEcallU;
            PrivS:   code = CauseEcallS;
            default: code = CauseEcallM;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if: bundles every trap-controller signal except clk/rst.
//   Core/CSR side inputs : pc_addr, exc_en/exc_code/exc_val, ecall, ebreak, mret,
//                          irq_valid/irq_code, mstatus_current, mtvec, mepc, redirect_ready
//   Controller outputs   : trap_taken, trap_done, mepc_next, mcause_next, mtval_next,
//                          mstatus_next, priv_lvl, flush, redirect_valid, redirect_pc
// Modports:
//   master - the trap controller itself (drives the CSR update and redirect signals)
//   slave  - the pipeline / CSR file / fetch unit around it
interface trap_controller_if;

    logic [63:0] pc_addr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        irq_valid;
    logic [3:0]  irq_code;
    logic [63:0] mstatus_current;
    logic [63:0] mtvec;
    logic [63:0] mepc;

    logic        trap_taken;
    logic        trap_done;
    logic [63:0] mepc_next;
    logic [63:0] mcause_next;
    logic [63:0] mtval_next;
    logic [63:0] mstatus_next;
    logic [1:0]  priv_lvl;
    logic        flush;

    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        input  pc_addr, exc_en, exc_code, exc_val, ecall, ebreak, mret,
        input  irq_valid, irq_code, mstatus_current, mtvec, mepc, redirect_ready,
        output trap_taken, trap_done, mepc_next, mcause_next, mtval_next, mstatus_next,
        output priv_lvl, flush, redirect_valid, redirect_pc
    );

    modport slave (
        output pc_addr, exc_en, exc_code, exc_val, ecall, ebreak, mret,
        output irq_valid, irq_code, mstatus_current, mtvec, mepc, redirect_ready,
        input  trap_taken, trap_done, mepc_next, mcause_next, mtval_next, mstatus_next,
        input  priv_lvl, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/trap_cause_encoder.sv
// trap_cause_encoder: combinational event prioritiser and cause/tval encoder.
// Ports:
//   exc_en, exc_code, exc_val  - CSR-access exception and its cause / faulting value
//   ecall, ebreak, mret        - decoded system-instruction strobes
//   irq_valid, irq_code        - pending (already mie/mip-masked) interrupt and cause
//   mie                        - global interrupt enable (mstatus.MIE)
//   priv_lvl                   - current privilege level
//   pc_addr                    - PC of the instruction at the trap point
//   trap_ev                    - an exception or interrupt must be taken
//   ret_ev                     - a legal mret must be executed
//   irq_ev                     - the taken trap is an interrupt (for vectoring)
//   cause, tval                - mcause / mtval values for a taken trap
// Priority: exc_en > ebreak > ecall > enabled interrupt > mret.
module trap_cause_encoder
    import trap_pkg::*;
(
    input  logic        exc_en,
    input  logic [3:0]  exc_code,
    input  logic [63:0] exc_val,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        irq_valid,
    input  logic [3:0]  irq_code,
    input  logic        mie,
    input  logic [1:0]  priv_lvl,
    input  logic [63:0] pc_addr,
    output logic        trap_ev,
    output logic        ret_ev,
    output logic        irq_ev,
    output logic [63:0] cause,
    output logic [63:0] tval
);

    always_comb begin
        trap_ev = 1'b0;
        ret_ev  = 1'b0;
        irq_ev  = 1'b0;
        cause   = '0;
        tval    = '0;

        if (exc_en) begin
            trap_ev = 1'b1;
            cause   = {60'd0, exc_code};
            tval    = exc_val;
        end else if (ebreak) begin
            trap_ev = 1'b1;
            cause   = {60'd0, CauseBreakpoint};
            tval    = pc_addr;
        end else if (ecall) begin
            trap_ev = 1'b1;
            cause   = {60'd0, ecall_cause(priv_lvl)};
        end else if (irq_valid && mie) begin
            trap_ev = 1'b1;
            irq_ev  = 1'b1;
            cause   = {1'b1, 59'd0, irq_code};
        end else if (mret) begin
            if (priv_lvl == PrivM) begin
                ret_ev = 1'b1;
            end else begin
                // mret below M-mode is an illegal instruction with mtval 0.
                trap_ev = 1'b1;
                cause   = {60'd0, CauseIllegalInstr};
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry / mret exit sequencer.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - trap_controller_if.master carrying event inputs, current CSR values,
//          CSR update strobes/values (trap_taken, trap_done, *_next), priv_lvl,
//          flush and the fetch redirect handshake (redirect_valid/pc/ready)
// Sequence: an event sampled in IDLE at cycle N gives a one-cycle ENTER or EXIT
// strobe at N+1, then REDIRECT from N+2 until redirect_ready. Events outside IDLE
// are dropped; the pipeline is held by flush meanwhile.
// Build option: define TRAP_VECTORED_EN to vector interrupts to base + 4*cause
// when mtvec[1:0] == 1. Without it every trap goes to the mtvec base.
module trap_controller
    import trap_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    trap_controller_if.master  bus
);

    trap_state_e state_q, state_d;
    logic [1:0]  priv_q, priv_d;
    logic [1:0]  ret_priv_q, ret_priv_d;
    logic [63:0] mepc_next_q, mepc_next_d;
    logic [63:0] mcause_next_q, mcause_next_d;
    logic [63:0] mtval_next_q, mtval_next_d;
    logic [63:0] mstatus_next_q, mstatus_next_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;

    logic        trap_ev;
    logic        ret_ev;
    logic        irq_ev;
    logic [63:0] ev_cause;
    logic [63:0] ev_tval;

    logic [63:0] enter_mstatus;
    logic [63:0] exit_mstatus;
    logic [1:0]  cur_mpp;
    logic [63:0] trap_target;

    trap_cause_encoder u_cause_encoder (
        .exc_en    (bus.exc_en),
        .exc_code  (bus.exc_code),
        .exc_val   (bus.exc_val),
        .ecall     (bus.ecall),
        .ebreak    (bus.ebreak),
        .mret      (bus.mret),
        .irq_valid (bus.irq_valid),
        .irq_code  (bus.irq_code),
        .mie       (bus.mstatus_current[MstatusMie]),
        .priv_lvl  (priv_q),
        .pc_addr   (bus.pc_addr),
        .trap_ev   (trap_ev),
        .ret_ev    (ret_ev),
        .irq_ev    (irq_ev),
        .cause     (ev_cause),
        .tval      (ev_tval)
    );

    // mstatus images for trap entry and mret, built from the current value.
    always_comb begin
        cur_mpp = bus.mstatus_current[MstatusMppHi:MstatusMppLo];

        enter_mstatus                            = bus.mstatus_current;
        enter_mstatus[MstatusMpie]               = bus.mstatus_current[MstatusMie];
        enter_mstatus[MstatusMie]                = 1'b0;
        enter_mstatus[MstatusMppHi:MstatusMppLo] = priv_q;

        exit_mstatus                            = bus.mstatus_current;
        exit_mstatus[MstatusMie]                = bus.mstatus_current[MstatusMpie];
        exit_mstatus[MstatusMpie]               = 1'b1;
        exit_mstatus[MstatusMppHi:MstatusMppLo] = PrivU;
    end

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_target = align4(bus.mtvec);
        if (irq_ev && (bus.mtvec[1:0] == 2'b01)) begin
            trap_target = align4(bus.mtvec) + {58'd0, bus.irq_code, 2'b00};
        end
    end
`else
    // Mode bits of mtvec have no effect in the direct-only build.
    logic unused_vec_mode;
    assign unused_vec_mode = ^{bus.mtvec[1:0], irq_ev};
    assign trap_target     = align4(bus.mtvec);
`endif

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        priv_d         = priv_q;
        ret_priv_d     = ret_priv_q;
        mepc_next_d    = mepc_next_q;
        mcause_next_d  = mcause_next_q;
        mtval_next_d   = mtval_next_q;
        mstatus_next_d = mstatus_next_q;
        redirect_pc_d  = redirect_pc_q;

        bus.trap_taken     = 1'b0;
        bus.trap_done      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.flush          = 1'b1;

        unique case (state_q)
            StIdle: begin
                bus.flush = 1'b0;
                if (trap_ev) begin
                    state_d        = StEnter;
                    mepc_next_d    = align4(bus.pc_addr);
                    mcause_next_d  = ev_cause;
                    mtval_next_d   = ev_tval;
                    mstatus_next_d = enter_mstatus;
                    redirect_pc_d  = trap_target;
                end else if (ret_ev) begin
                    state_d        = StExit;
                    // mcause/mtval keep their previous values on return.
                    mepc_next_d    = bus.mepc;
                    mstatus_next_d = exit_mstatus;
                    redirect_pc_d  = align4(bus.mepc);
                    // MPP=2 is reserved; fall back to U-mode.
                    ret_priv_d     = (cur_mpp == 2'b10) ? PrivU : cur_mpp;
                end
            end
            StEnter: begin
                bus.trap_taken = 1'b1;
                priv_d         = PrivM;
                state_d        = StRedirect;
            end
            StExit: begin
                bus.trap_done = 1'b1;
                priv_d        = ret_priv_q;
                state_d       = StRedirect;
            end
            StRedirect: begin
                bus.redirect_valid = 1'b1;
                if (bus.redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            priv_q         <= PrivM;
            ret_priv_q     <= PrivU;
            mepc_next_q    <= '0;
            mcause_next_q  <= '0;
            mtval_next_q   <= '0;
            mstatus_next_q <= '0;
            redirect_pc_q  <= '0;
        end else begin
            state_q        <= state_d;
            priv_q         <= priv_d;
            ret_priv_q     <= ret_priv_d;
            mepc_next_q    <= mepc_next_d;
            mcause_next_q  <= mcause_next_d;
            mtval_next_q   <= mtval_next_d;
            mstatus_next_q <= mstatus_next_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign bus.priv_lvl     = priv_q;
    assign bus.mepc_next    = mepc_next_q;
    assign bus.mcause_next  = mcause_next_q;
    assign bus.mtval_next   = mtval_next_q;
    assign bus.mstatus_next = mstatus_next_q;
    assign bus.redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed-vector bench for trap_controller with a
// transaction-level reference model and a per-cycle compare process.
// Honours TRAP_VECTORED_EN the same way as the design build.
module tb_trap_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_controller_if bus ();

    trap_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit armed    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        is_ret;
        logic [63:0] cause;
        logic [63:0] tval;
        logic [63:0] mepc;
        logic [63:0] mstatus;
        logic [63:0] target;
        logic [1:0]  new_priv;
        int          due;
    } txn_t;

    // Model state: one outstanding transaction at most.
    txn_t        cur;
    bit          busy       = 1'b0;
    logic [1:0]  m_priv     = 2'd3;
    logic [63:0] last_cause = '0;
    logic [63:0] last_tval  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    // What the controller must do with the inputs currently on the bus.
    function automatic bit predict(output txn_t t);
        logic [63:0] mst;
        logic [63:0] base;
        logic [1:0]  mpp;
        bit          fire;
        bit          irq;
        mst  = bus.mstatus_current;
        base = bus.mtvec & ~64'h3;
        mpp  = mst[12:11];
        fire = 1'b1;
        irq  = 1'b0;
        t    = '0;
        if (bus.exc_en) begin
            t.cause = 64'(bus.exc_code);
            t.tval  = bus.exc_val;
        end else if (bus.ebreak) begin
            t.cause = 64'd3;
            t.tval  = bus.pc_addr;
        end else if (bus.ecall) begin
            t.cause = 64'd8 + 64'(m_priv);
        end else if (bus.irq_valid && mst[3]) begin
            t.cause = (64'd1 << 63) | 64'(bus.irq_code);
            irq     = 1'b1;
        end else if (bus.mret && m_priv == 2'd3) begin
            t.is_ret = 1'b1;
        end else if (bus.mret) begin
            t.cause = 64'd2;
        end else begin
            fire = 1'b0;
        end
        if (t.is_ret) begin
            t.cause    = last_cause;
            t.tval     = last_tval;
            t.mepc     = bus.mepc;
            t.mstatus  = (mst & ~64'h1888) | 64'h80 | (mst[7] ? 64'h8 : 64'h0);
            t.target   = bus.mepc & ~64'h3;
            t.new_priv = (mpp == 2'd2) ? 2'd0 : mpp;
        end else begin
            t.mepc     = bus.pc_addr & ~64'h3;
            t.mstatus  = (mst & ~64'h1888) | (mst[3] ? 64'h80 : 64'h0) | (64'(m_priv) << 11);
            t.target   = base;
`ifdef TRAP_VECTORED_EN
            if (irq && bus.mtvec[1:0] == 2'd1) t.target = base + 64'(bus.irq_code) * 64'd4;
`endif
            t.new_priv = 2'd3;
        end
        return fire;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst) begin
            busy       = 1'b0;
            m_priv     = 2'd3;
            last_cause = '0;
            last_tval  = '0;
        end else if (armed) begin
            chk("strobe_exclusive", 64'(bus.trap_taken & bus.trap_done), 64'd0);
            chk("priv_lvl", 64'(bus.priv_lvl), 64'(m_priv));
            if (!busy || cyc < cur.due) begin
                chk("idle_flush", 64'(bus.flush), 64'd0);
                chk("idle_trap_taken", 64'(bus.trap_taken), 64'd0);
                chk("idle_trap_done", 64'(bus.trap_done), 64'd0);
                chk("idle_redirect_valid", 64'(bus.redirect_valid), 64'd0);
            end else if (cyc == cur.due) begin
                chk("trap_taken", 64'(bus.trap_taken), 64'(!cur.is_ret));
                chk("trap_done", 64'(bus.trap_done), 64'(cur.is_ret));
                chk("strobe_flush", 64'(bus.flush), 64'd1);
                chk("strobe_redirect_valid", 64'(bus.redirect_valid), 64'd0);
                chk("mepc_next", bus.mepc_next, cur.mepc);
                chk("mcause_next", bus.mcause_next, cur.cause);
                chk("mtval_next", bus.mtval_next, cur.tval);
                chk("mstatus_next", bus.mstatus_next, cur.mstatus);
                m_priv     = cur.new_priv;
                last_cause = cur.cause;
                last_tval  = cur.tval;
            end else begin
                chk("redir_flush", 64'(bus.flush), 64'd1);
                chk("redirect_valid", 64'(bus.redirect_valid), 64'd1);
                chk("redirect_pc", bus.redirect_pc, cur.target);
                chk("redir_trap_taken", 64'(bus.trap_taken), 64'd0);
                chk("redir_trap_done", 64'(bus.trap_done), 64'd0);
                if (bus.redirect_ready) begin
                    busy = 1'b0;
                end else if (cyc - cur.due > 60) begin
                    checks++;
                    failures++;
                    $display("FAIL redirect_timeout at cycle %0d: still waiting", cyc);
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        bus.exc_en    = 1'b0;
        bus.ecall     = 1'b0;
        bus.ebreak    = 1'b0;
        bus.mret      = 1'b0;
        bus.irq_valid = 1'b0;
    endtask

    // Offer the current inputs for one cycle; the model records it if IDLE.
    task automatic issue();
        txn_t t;
        if (!busy && predict(t)) begin
            t.due = cyc + 1;
            cur   = t;
            busy  = 1'b1;
        end
    endtask

    // Issue, drop the event, and stop on the negedge of the strobe cycle.
    task automatic fire();
        issue();
        tick();
        clear_ev();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && busy; i++) tick();
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle at cycle %0d: transaction never completed", cyc);
            busy = 1'b0;
        end
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_ev();
        bus.pc_addr         = '0;
        bus.exc_code        = '0;
        bus.exc_val         = '0;
        bus.irq_code        = '0;
        bus.mstatus_current = '0;
        bus.mtvec           = '0;
        bus.mepc            = '0;
        bus.redirect_ready  = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst   = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_priv", 64'(bus.priv_lvl), 64'd3);
        chk("rst_flush", 64'(bus.flush), 64'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
        chk("rst_mcause", bus.mcause_next, 64'd0);
        chk("rst_mstatus", bus.mstatus_next, 64'd0);
        tick();

        // mret from M with MPIE=1, MPP=U.
        bus.mret = 1'b1; bus.mepc = 64'h1004; bus.mstatus_current = 64'h80;
        fire();
        chk("r31_trap_done", 64'(bus.trap_done), 64'd1);
        chk("r31_mstatus_next", bus.mstatus_next, 64'h88);
        @(negedge clk);
        chk("r31_priv", 64'(bus.priv_lvl), 64'd0);
        chk("r31_redirect_pc", bus.redirect_pc, 64'h1004);
        wait_idle();

        // U-mode ecall; fetch stalls the redirect for 5 cycles while ecall repeats.
        bus.ecall = 1'b1; bus.pc_addr = 64'h1000; bus.mtvec = 64'h8000;
        bus.mstatus_current = 64'h8; bus.redirect_ready = 1'b0;
        fire();
        chk("r30_trap_taken", 64'(bus.trap_taken), 64'd1);
        chk("r30_mcause", bus.mcause_next, 64'd8);
        chk("r30_mepc", bus.mepc_next, 64'h1000);
        chk("r30_mstatus", bus.mstatus_next, 64'h80);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.ecall = 1'b1;
            issue();
            @(negedge clk);
            chk("r34_redirect_pc", bus.redirect_pc, 64'h8000);
            chk("r34_priv", 64'(bus.priv_lvl), 64'd3);
        end
        tick();
        clear_ev();
        bus.redirect_ready = 1'b1;
        wait_idle();
        repeat (2) tick();

        // CSR exception wins over a simultaneous ecall.
        bus.exc_en = 1'b1; bus.exc_code = 4'd2; bus.exc_val = 64'h305; bus.ecall = 1'b1;
        bus.pc_addr = 64'h2000;
        fire();
        chk("r32_mcause", bus.mcause_next, 64'd2);
        chk("r32_mtval", bus.mtval_next, 64'h305);
        wait_idle();

        // Interrupt with MIE=1 and vectored-mode mtvec.
        bus.irq_valid = 1'b1; bus.irq_code = 4'd7; bus.mtvec = 64'h8001;
        bus.mstatus_current = 64'h8;
        fire();
        chk("r33_mcause", bus.mcause_next, 64'h8000000000000007);
        @(negedge clk);
`ifdef TRAP_VECTORED_EN
        chk("r33_redirect_pc", bus.redirect_pc, 64'h801C);
`else
        chk("r33_redirect_pc", bus.redirect_pc, 64'h8000);
`endif
        wait_idle();
        // Same interrupt with MIE=0 must be ignored.
        bus.mstatus_current = 64'h0;
        for (int i = 0; i < 3; i++) begin
            bus.irq_valid = 1'b1;
            issue();
            tick();
        end
        clear_ev();
        @(negedge clk);
        chk("r33_masked_flush", 64'(bus.flush), 64'd0);
        tick();

        // ebreak beats an enabled interrupt; PC is unaligned.
        bus.ebreak = 1'b1; bus.irq_valid = 1'b1; bus.mstatus_current = 64'h8;
        bus.pc_addr = 64'h2006; bus.mtvec = 64'h9000;
        fire();
        chk("ebreak_mcause", bus.mcause_next, 64'd3);
        chk("ebreak_mtval", bus.mtval_next, 64'h2006);
        chk("ebreak_mepc", bus.mepc_next, 64'h2004);
        chk("ebreak_mstatus", bus.mstatus_next, 64'h1880);
        wait_idle();

        // mret to U, then mret in U is illegal.
        bus.mret = 1'b1; bus.mstatus_current = 64'h0; bus.mepc = 64'h3000;
        fire();
        wait_idle();
        bus.mret = 1'b1; bus.pc_addr = 64'h3000;
        fire();
        chk("r35_trap_taken", 64'(bus.trap_taken), 64'd1);
        chk("r35_mcause", bus.mcause_next, 64'd2);
        chk("r35_mtval", bus.mtval_next, 64'd0);
        @(negedge clk);
        chk("r35_priv", 64'(bus.priv_lvl), 64'd3);
        wait_idle();

        // Return to S, ecall from S; return with reserved MPP=2, then ecall U and M.
        bus.mret = 1'b1; bus.mstatus_current = 64'h0800; bus.mepc = 64'h4000;
        fire();
        wait_idle();
        bus.ecall = 1'b1; bus.pc_addr = 64'h4000;
        fire();
        chk("ecall_s_mcause", bus.mcause_next, 64'd9);
        wait_idle();
        bus.mret = 1'b1; bus.mstatus_current = 64'h1000;
        fire();
        @(negedge clk);
        chk("mpp2_priv", 64'(bus.priv_lvl), 64'd0);
        wait_idle();
        bus.ecall = 1'b1;
        fire();
        chk("ecall_u_mcause", bus.mcause_next, 64'd8);
        wait_idle();
        bus.ecall = 1'b1;
        fire();
        chk("ecall_m_mcause", bus.mcause_next, 64'd11);
        wait_idle();

        // Reset while stalled in REDIRECT after a return to U.
        bus.mret = 1'b1; bus.mstatus_current = 64'h0; bus.mepc = 64'h5000;
        bus.redirect_ready = 1'b0;
        fire();
        @(negedge clk);
        chk("r34_pre_rst_priv", 64'(bus.priv_lvl), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.redirect_ready = 1'b1;
        @(negedge clk);
        chk("r34_rst_priv", 64'(bus.priv_lvl), 64'd3);
        chk("r34_rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        chk("r34_rst_redirect_pc", bus.redirect_pc, 64'd0);
        chk("r34_rst_mstatus", bus.mstatus_next, 64'd0);
        tick();

        // Controller is usable again after reset.
        bus.ecall = 1'b1; bus.pc_addr = 64'h6000; bus.mtvec = 64'hA000;
        fire();
        chk("post_rst_mcause", bus.mcause_next, 64'd11);
        wait_idle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
